// File: rtl/dpsk_mod_mapper.sv
// dpsk_mod_mapper
// Differential-PSK (BPSK-DPSK) mapper placed after the NCO. One data bit is
// accepted per symbol through a valid/ready handshake, differentially encoded
// against the previous symbol phase, and used to pass the carrier through
// unchanged (phase 0) or negated with saturation (phase 1).
//
// Parameters
//   MPR  carrier / output sample width (two's complement)
//   SPS  carrier samples per symbol (2..65535)
//   CW   symbol counter width, 2^CW >= SPS
//
// Ports
//   clk, reset     clock and synchronous active-high reset
//   clken          clock enable; all registers hold while low
//   car_i          carrier sample from the NCO
//   car_valid_i    carrier sample strobe
//   bit_i          data bit
//   bit_valid_i    data bit valid
//   bit_ready_o    a bit is taken on the current sample strobe
//   dpsk_o         registered modulated sample
//   dpsk_valid_o   dpsk_o carries a modulated sample
//   sym_start_o    dpsk_o is the first sample of a symbol
//   underrun_o     sticky: a symbol boundary passed with no bit available
module dpsk_mod_mapper #(
    parameter int MPR = 10,
    parameter int SPS = 16,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic [MPR-1:0] car_i,
    input  logic           car_valid_i,
    input  logic           bit_i,
    input  logic           bit_valid_i,
    output logic           bit_ready_o,
    output logic [MPR-1:0] dpsk_o,
    output logic           dpsk_valid_o,
    output logic           sym_start_o,
    output logic           underrun_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);

    // Two's-complement negation clamped so the most negative code maps to
    // the most positive one instead of wrapping onto itself.
    function automatic logic signed [MPR-1:0] sat_neg(input logic signed [MPR-1:0] x);
        logic signed [MPR-1:0] most_neg;
        most_neg = {1'b1, {(MPR-1){1'b0}}};
        if (x == most_neg) begin
            sat_neg = {1'b0, {(MPR-1){1'b1}}};
        end else begin
            sat_neg = -x;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   d_prev_q, d_prev_d;
    logic signed [MPR-1:0]  dpsk_q, dpsk_d;
    logic                   dpsk_valid_q, dpsk_valid_d;
    logic                   sym_start_q, sym_start_d;
    logic                   underrun_q, underrun_d;

    logic                   stb;
    logic                   xfer;
    logic                   d_new;
    logic                   d_cur;
    logic                   map_en;
    logic signed [MPR-1:0]  car_s;

    // cnt_q is the index of the next sample within the running symbol. It
    // wraps to 0 after the last sample, so in RUN a count of 0 marks the
    // strobe that must begin the next symbol (or fall back to IDLE).
    assign stb         = clken & car_valid_i;
    assign bit_ready_o = (state_q == IDLE) | ((state_q == RUN) & (cnt_q == '0));
    assign xfer        = stb & bit_valid_i & bit_ready_o;
    assign d_new       = bit_i ^ d_prev_q;
    assign d_cur       = xfer ? d_new : d_prev_q;
    assign car_s       = $signed(car_i);
    assign map_en      = xfer | ((state_q == RUN) & (cnt_q != '0));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        d_prev_d     = d_prev_q;
        dpsk_d       = dpsk_q;
        dpsk_valid_d = dpsk_valid_q;
        sym_start_d  = sym_start_q;
        underrun_d   = underrun_q;

        // Enabled cycle without a carrier sample: flags drop, data holds.
        if (clken) begin
            dpsk_valid_d = 1'b0;
            sym_start_d  = 1'b0;
        end

        if (stb) begin
            if (xfer) begin
                state_d  = RUN;
                cnt_d    = CW'(1);
                d_prev_d = d_new;
            end else if (state_q == RUN) begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    underrun_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            if (map_en) begin
                dpsk_d       = d_cur ? sat_neg(car_s) : car_s;
                dpsk_valid_d = 1'b1;
                sym_start_d  = xfer;
            end else begin
                dpsk_d       = '0;
                dpsk_valid_d = 1'b0;
                sym_start_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            d_prev_q     <= 1'b0;
            dpsk_q       <= '0;
            dpsk_valid_q <= 1'b0;
            sym_start_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            d_prev_q     <= d_prev_d;
            dpsk_q       <= dpsk_d;
            dpsk_valid_q <= dpsk_valid_d;
            sym_start_q  <= sym_start_d;
            underrun_q   <= underrun_d;
        end
    end

    assign dpsk_o       = dpsk_q;
    assign dpsk_valid_o = dpsk_valid_q;
    assign sym_start_o  = sym_start_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_dpsk_mod_mapper.sv
// Directed bench for dpsk_mod_mapper with SPS=4, MPR=10.
module tb_dpsk_mod_mapper;

    localparam int MPR = 10;
    localparam int SPS = 4;
    localparam int CW  = 16;

    logic           clk;
    logic           reset;
    logic           clken;
    logic [MPR-1:0] car_i;
    logic           car_valid_i;
    logic           bit_i;
    logic           bit_valid_i;
    logic           bit_ready_o;
    logic [MPR-1:0] dpsk_o;
    logic           dpsk_valid_o;
    logic           sym_start_o;
    logic           underrun_o;

    int errors = 0;
    int checks = 0;

    dpsk_mod_mapper #(.MPR(MPR), .SPS(SPS), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .clken        (clken),
        .car_i        (car_i),
        .car_valid_i  (car_valid_i),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .dpsk_o       (dpsk_o),
        .dpsk_valid_o (dpsk_valid_o),
        .sym_start_o  (sym_start_o),
        .underrun_o   (underrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int car, input logic cv, input logic b, input logic bv);
        car_i       = MPR'(car);
        car_valid_i = cv;
        bit_i       = b;
        bit_valid_i = bv;
    endtask

    task automatic do_reset();
        drive(0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic signed [31:0] dout;
    assign dout = {{(32-MPR){dpsk_o[MPR-1]}}, dpsk_o};

    initial begin
        int phases [3];
        int bits [3];
        phases = '{1, 0, 0};
        bits   = '{1, 1, 0};
        clken  = 1'b1;
        reset  = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0);

        // Reset held with live strobes.
        for (int i = 0; i < 20; i++) begin
            drive(i + 3, 1'b1, 1'b0, 1'b0);
            tick();
            chk("rst_valid", 32'(dpsk_valid_o), 0);
            chk("rst_dpsk", dout, 0);
            chk("rst_ready", 32'(bit_ready_o), 1);
            chk("rst_underrun", 32'(underrun_o), 0);
            chk("rst_symstart", 32'(sym_start_o), 0);
        end
        reset = 1'b0;

        // Continuous streaming of bits 1,1,0 -> phases 1,0,0.
        for (int k = 1; k <= 12; k++) begin
            drive(k, 1'b1, 1'(bits[(k-1)/4]), 1'b1);
            #1;
            chk("stream_ready", 32'(bit_ready_o), ((k-1) % 4 == 0) ? 1 : 0);
            tick();
            chk("stream_dpsk", dout, (phases[(k-1)/4] == 1) ? -k : k);
            chk("stream_valid", 32'(dpsk_valid_o), 1);
            chk("stream_symstart", 32'(sym_start_o), ((k-1) % 4 == 0) ? 1 : 0);
            chk("stream_underrun", 32'(underrun_o), 0);
        end
        drive(13, 1'b1, 1'b0, 1'b0);
        tick();
        chk("stream_end_valid", 32'(dpsk_valid_o), 0);
        chk("stream_end_dpsk", dout, 0);
        chk("stream_end_underrun", 32'(underrun_o), 1);
        do_reset();
        chk("reset2_underrun", 32'(underrun_o), 0);

        // Strobe every other cycle, bits 1,0 -> phases 1,1.
        for (int j = 0; j < 16; j++) begin
            drive(20 + j, (j % 2 == 0), 1'((j / 8) == 0 ? 1 : 0), 1'b1);
            tick();
            if (j % 2 == 0) begin
                chk("gap_dpsk", dout, -(20 + j));
                chk("gap_valid", 32'(dpsk_valid_o), 1);
                chk("gap_symstart", 32'(sym_start_o), ((j / 2) % 4 == 0) ? 1 : 0);
            end else begin
                chk("gap_hold_dpsk", dout, -(20 + j - 1));
                chk("gap_hold_valid", 32'(dpsk_valid_o), 0);
                chk("gap_hold_symstart", 32'(sym_start_o), 0);
            end
        end
        do_reset();

        // One bit, then starvation -> underrun, IDLE, later restart.
        drive(5, 1'b1, 1'b1, 1'b1);
        tick();
        chk("ur_s0", dout, -5);
        chk("ur_s0_start", 32'(sym_start_o), 1);
        for (int k = 6; k <= 8; k++) begin
            drive(k, 1'b1, 1'b0, 1'b0);
            tick();
            chk("ur_dpsk", dout, -k);
            chk("ur_valid", 32'(dpsk_valid_o), 1);
            chk("ur_start", 32'(sym_start_o), 0);
        end
        drive(9, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ur_drop_valid", 32'(dpsk_valid_o), 0);
        chk("ur_drop_dpsk", dout, 0);
        chk("ur_flag", 32'(underrun_o), 1);
        chk("ur_ready", 32'(bit_ready_o), 1);
        for (int k = 0; k < 2; k++) begin
            drive(10 + k, 1'b1, 1'b0, 1'b0);
            tick();
            chk("ur_idle_valid", 32'(dpsk_valid_o), 0);
            chk("ur_sticky", 32'(underrun_o), 1);
        end
        drive(30, 1'b1, 1'b0, 1'b1);
        tick();
        chk("restart_dpsk", dout, -30);
        chk("restart_start", 32'(sym_start_o), 1);
        chk("restart_sticky", 32'(underrun_o), 1);
        drive(-512, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sat_neg_min", dout, 511);
        drive(511, 1'b1, 1'b0, 1'b0);
        tick();
        chk("neg_max", dout, -511);
        drive(0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("neg_zero", dout, 0);
        chk("neg_zero_valid", 32'(dpsk_valid_o), 1);
        do_reset();

        // Reset in the middle of a phase-1 symbol.
        drive(1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(2, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mid_pre", dout, -2);
        reset = 1'b1;
        drive(3, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        chk("mid_rst_dpsk", dout, 0);
        chk("mid_rst_valid", 32'(dpsk_valid_o), 0);
        chk("mid_rst_start", 32'(sym_start_o), 0);
        chk("mid_rst_ready", 32'(bit_ready_o), 1);
        chk("mid_rst_underrun", 32'(underrun_o), 0);
        drive(40, 1'b1, 1'b1, 1'b1);
        tick();
        chk("mid_after_dpsk", dout, -40);
        chk("mid_after_start", 32'(sym_start_o), 1);

        // clken low freezes everything, including over strobes.
        clken = 1'b0;
        drive(77, 1'b1, 1'b0, 1'b0);
        tick();
        chk("clken_hold_dpsk", dout, -40);
        chk("clken_hold_valid", 32'(dpsk_valid_o), 1);
        clken = 1'b1;
        tick();
        chk("clken_resume", dout, -77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
